// File: rtl/lsu_bus_unit.sv
// Load/store unit between the ALU and the data-memory bus.
// Drives one req/ack transaction per access, stalls the core while it runs,
// and reports each access as either a done pulse or a fault pulse.
//
// state | meaning
// ------+-----------------------------------------------------------------
// IDLE  | no access in flight; a request is decoded and launched or rejected
// REQ   | bus_req held, waiting for bus_ack or the timeout
// RESP  | single retire cycle: done or fault pulse, stall released
module lsu_bus_unit #(
    parameter int TIMEOUT_CYCLES = 16,
    parameter int CNT_W          = 5
) (
    input  logic        clk,
    input  logic        rst,
    input  logic        mem_read,
    input  logic        mem_write,
    input  logic [2:0]  funct3,
    input  logic [31:0] addr,
    input  logic [31:0] store_data,
    output logic        bus_req,
    output logic        bus_we,
    output logic [31:0] bus_addr,
    output logic [31:0] bus_wdata,
    output logic [3:0]  bus_wstrb,
    input  logic        bus_ack,
    input  logic [31:0] bus_rdata,
    output logic [31:0] load_data,
    output logic        stall,
    output logic        done,
    output logic        fault
);

    typedef enum logic [1:0] {IDLE, REQ, RESP} state_t;

    localparam logic [CNT_W-1:0] TO_LAST = CNT_W'(TIMEOUT_CYCLES - 1);

    state_t           state_q, state_d;
    logic [CNT_W-1:0] cnt_q;
    logic [2:0]       f3_q;
    logic [1:0]       off_q;
    logic             resp_ok_q;

    logic             req_any, illegal, f3_ok, misaligned;
    logic             start, finish_ok, finish_bad, cnt_inc, stall_c;
    logic [31:0]      wdata_lane, load_ext;
    logic [3:0]       wstrb_lane;
    logic [7:0]       rd_byte;
    logic [15:0]      rd_half;

    // Request legality and store lane formatting from the live inputs.
    always_comb begin
        req_any    = mem_read | mem_write;
        f3_ok      = mem_write ? (funct3 inside {3'b000, 3'b001, 3'b010})
                               : (funct3 inside {3'b000, 3'b001, 3'b010, 3'b100, 3'b101});
        misaligned = ((funct3[1:0] == 2'b01) && addr[0]) ||
                     ((funct3[1:0] == 2'b10) && (addr[1:0] != 2'b00));
        illegal    = (mem_read & mem_write) | ~f3_ok | misaligned;
        wdata_lane = store_data;
        wstrb_lane = 4'b1111;
        case (funct3[1:0])
            2'b00: begin
                wdata_lane = {4{store_data[7:0]}};
                wstrb_lane = 4'b0001 << addr[1:0];
            end
            2'b01: begin
                wdata_lane = {2{store_data[15:0]}};
                wstrb_lane = addr[1] ? 4'b1100 : 4'b0011;
            end
            default: ;
        endcase
    end

    // Load extraction uses the size and byte offset captured at launch.
    always_comb begin
        rd_byte  = bus_rdata[{off_q, 3'b000} +: 8];
        rd_half  = off_q[1] ? bus_rdata[31:16] : bus_rdata[15:0];
        load_ext = bus_rdata;
        case (f3_q[1:0])
            2'b00:   load_ext = {{24{~f3_q[2] & rd_byte[7]}}, rd_byte};
            2'b01:   load_ext = {{16{~f3_q[2] & rd_half[15]}}, rd_half};
            default: load_ext = bus_rdata;
        endcase
    end

    // State register.
    always_ff @(posedge clk or negedge rst) begin
        if (!rst) state_q <= IDLE;
        else      state_q <= state_d;
    end

    // Next-state and per-cycle control; an ack in the last timeout cycle wins.
    always_comb begin
        state_d    = state_q;
        stall_c    = 1'b0;
        start      = 1'b0;
        finish_ok  = 1'b0;
        finish_bad = 1'b0;
        cnt_inc    = 1'b0;
        case (state_q)
            IDLE: begin
                if (req_any) begin
                    stall_c = 1'b1;
                    if (illegal) begin
                        finish_bad = 1'b1;
                        state_d    = RESP;
                    end else begin
                        start   = 1'b1;
                        state_d = REQ;
                    end
                end
            end
            REQ: begin
                stall_c = 1'b1;
                if (bus_ack) begin
                    finish_ok = 1'b1;
                    state_d   = RESP;
                end else if (cnt_q == TO_LAST) begin
                    finish_bad = 1'b1;
                    state_d    = RESP;
                end else begin
                    cnt_inc = 1'b1;
                end
            end
            RESP:    state_d = IDLE;
            default: state_d = IDLE;
        endcase
    end

    // Bus launch registers, timeout counter, load result and outcome flag.
    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            bus_req   <= 1'b0;
            bus_we    <= 1'b0;
            bus_addr  <= '0;
            bus_wdata <= '0;
            bus_wstrb <= '0;
            load_data <= '0;
            cnt_q     <= '0;
            f3_q      <= '0;
            off_q     <= '0;
            resp_ok_q <= 1'b0;
        end else begin
            if (start) begin
                bus_req   <= 1'b1;
                bus_we    <= mem_write;
                bus_addr  <= {addr[31:2], 2'b00};
                bus_wdata <= wdata_lane;
                bus_wstrb <= mem_write ? wstrb_lane : 4'b0000;
                f3_q      <= funct3;
                off_q     <= addr[1:0];
                cnt_q     <= '0;
            end
            if (cnt_inc) cnt_q <= cnt_q + 1'b1;
            if (finish_ok || finish_bad) begin
                bus_req   <= 1'b0;
                resp_ok_q <= finish_ok;
            end
            if (finish_ok && !bus_we) load_data <= load_ext;
        end
    end

    // Stall is forced low while reset is asserted, even with a request held.
    assign stall = rst & stall_c;
    assign done  = (state_q == RESP) &  resp_ok_q;
    assign fault = (state_q == RESP) & ~resp_ok_q;

endmodule

// File: tb/tb_lsu_bus_unit.sv
// Scoreboard bench: stimulus pushes expected bus launches and responses,
// a negedge monitor pops and compares them as the DUT presents them.
module tb_lsu_bus_unit;

    logic        clk = 1'b0;
    logic        rst = 1'b0;
    logic        mem_read = 1'b0, mem_write = 1'b0;
    logic [2:0]  funct3 = '0;
    logic [31:0] addr = '0, store_data = '0;
    logic        bus_req, bus_we, bus_ack = 1'b0;
    logic [31:0] bus_addr, bus_wdata, bus_rdata = '0, load_data;
    logic [3:0]  bus_wstrb;
    logic        stall, done, fault;

    lsu_bus_unit #(.TIMEOUT_CYCLES(16), .CNT_W(5)) dut (
        .clk(clk), .rst(rst), .mem_read(mem_read), .mem_write(mem_write),
        .funct3(funct3), .addr(addr), .store_data(store_data),
        .bus_req(bus_req), .bus_we(bus_we), .bus_addr(bus_addr),
        .bus_wdata(bus_wdata), .bus_wstrb(bus_wstrb), .bus_ack(bus_ack),
        .bus_rdata(bus_rdata), .load_data(load_data), .stall(stall),
        .done(done), .fault(fault)
    );

    always #5 clk = ~clk;

    typedef struct { logic is_fault; logic [31:0] ld; } resp_t;
    typedef struct { logic [31:0] a; logic we; logic [31:0] wd; logic [3:0] ws; } bus_t;

    resp_t resp_q[$];
    bus_t  bus_q[$];
    int checks = 0, errors = 0;
    int stall_cnt = 0, req_cnt = 0;
    logic req_prev = 1'b0;

    task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s: got 0x%08h expected 0x%08h", name, act, exp);
        end
    endtask

    task automatic exp_resp(input logic f, input logic [31:0] ld);
        resp_t r;
        r.is_fault = f; r.ld = ld;
        resp_q.push_back(r);
    endtask

    task automatic exp_bus(input logic [31:0] a, input logic we, input logic [31:0] wd, input logic [3:0] ws);
        bus_t b;
        b.a = a; b.we = we; b.wd = wd; b.ws = ws;
        bus_q.push_back(b);
    endtask

    // Monitor: compares every launch and every retire pulse against the queues.
    always @(negedge clk) begin
        if (!rst) begin
            req_prev = 1'b0;
        end else begin
            if (stall)   stall_cnt++;
            if (bus_req) req_cnt++;
            if (done || fault) begin
                checks++;
                if (resp_q.size() == 0) begin
                    errors++;
                    $display("FAIL resp_unexpected: got done=%0b fault=%0b expected no pulse", done, fault);
                end else begin
                    resp_t r;
                    r = resp_q.pop_front();
                    if (done === fault || fault !== r.is_fault || load_data !== r.ld) begin
                        errors++;
                        $display("FAIL resp: got done=%0b fault=%0b load_data=0x%08h expected fault=%0b load_data=0x%08h",
                                 done, fault, load_data, r.is_fault, r.ld);
                    end
                end
            end
            if (bus_req && !req_prev) begin
                checks++;
                if (bus_q.size() == 0) begin
                    errors++;
                    $display("FAIL bus_unexpected: got bus_req rise at addr 0x%08h expected none", bus_addr);
                end else begin
                    bus_t b;
                    b = bus_q.pop_front();
                    if (bus_addr !== b.a || bus_we !== b.we || bus_wstrb !== b.ws ||
                        (b.we && bus_wdata !== b.wd)) begin
                        errors++;
                        $display("FAIL bus: got a=0x%08h we=%0b wd=0x%08h ws=%04b expected a=0x%08h we=%0b wd=0x%08h ws=%04b",
                                 bus_addr, bus_we, bus_wdata, bus_wstrb, b.a, b.we, b.wd, b.ws);
                    end
                end
            end
            req_prev = bus_req;
        end
    end

    // Runs one access starting in the current cycle (cycle 0); ack_at is the
    // cycle index that carries bus_ack (0 = never). Returns the RESP cycle index.
    task automatic access(input logic rd, input logic wr, input logic [2:0] f3,
                          input logic [31:0] a, input logic [31:0] sd,
                          input int ack_at, input logic [31:0] rdat, output int resp_at);
        stall_cnt = 0; req_cnt = 0; resp_at = -1;
        mem_read = rd; mem_write = wr; funct3 = f3; addr = a;
        store_data = sd; bus_rdata = rdat; bus_ack = 1'b0;
        for (int i = 1; i <= 40; i++) begin
            @(posedge clk); #1;
            if (done || fault) begin
                resp_at = i;
                break;
            end
            bus_ack = (i == ack_at);
        end
        bus_ack = 1'b0; mem_read = 1'b0; mem_write = 1'b0;
        if (resp_at < 0) begin
            checks++; errors++;
            $display("FAIL wait_resp: got no done/fault within 40 cycles expected a response");
        end
    endtask

    int ra;

    initial begin
        // Reset state
        #12;
        chk("rst_outputs", {bus_req, bus_we, stall, done, fault, bus_wstrb}, '0);
        chk("rst_addr", bus_addr, 32'h0);
        chk("rst_load", load_data, 32'h0);
        @(posedge clk); #1; rst = 1'b1;
        @(posedge clk); #1;

        // lb at 0x103, ack in 2nd REQ cycle
        exp_bus(32'h100, 1'b0, 32'h0, 4'b0000);
        exp_resp(1'b0, 32'hFFFF_FF80);
        access(1'b1, 1'b0, 3'b000, 32'h103, 32'h0, 2, 32'h80FF_1234, ra);
        chk("lb_resp_cycle", ra, 3);
        chk("lb_stall_cycles", stall_cnt, 3);
        chk("lb_req_cycles", req_cnt, 2);

        @(posedge clk); #1;
        exp_bus(32'h100, 1'b0, 32'h0, 4'b0000);
        exp_resp(1'b0, 32'h0000_0080);
        access(1'b1, 1'b0, 3'b100, 32'h103, 32'h0, 2, 32'h80FF_1234, ra);

        // halfword loads from the upper lane, and minimum-latency word load
        @(posedge clk); #1;
        exp_bus(32'h104, 1'b0, 32'h0, 4'b0000);
        exp_resp(1'b0, 32'hFFFF_80FF);
        access(1'b1, 1'b0, 3'b001, 32'h106, 32'h0, 1, 32'h80FF_1234, ra);
        chk("lh_min_latency", ra, 2);
        chk("lh_stall_cycles", stall_cnt, 2);
        @(posedge clk); #1;
        exp_bus(32'h104, 1'b0, 32'h0, 4'b0000);
        exp_resp(1'b0, 32'h0000_80FF);
        access(1'b1, 1'b0, 3'b101, 32'h106, 32'h0, 1, 32'h80FF_1234, ra);

        // Stores: load_data must keep 0x000080FF
        @(posedge clk); #1;
        exp_bus(32'h200, 1'b1, 32'hBEEF_BEEF, 4'b1100);
        exp_resp(1'b0, 32'h0000_80FF);
        access(1'b0, 1'b1, 3'b001, 32'h202, 32'hDEAD_BEEF, 1, 32'hFFFF_FFFF, ra);
        @(posedge clk); #1;
        exp_bus(32'h200, 1'b1, 32'hEFEF_EFEF, 4'b0010);
        exp_resp(1'b0, 32'h0000_80FF);
        access(1'b0, 1'b1, 3'b000, 32'h201, 32'hDEAD_BEEF, 1, 32'hFFFF_FFFF, ra);

        // Illegal accesses: fault in the cycle after the request, no bus activity
        @(posedge clk); #1;
        exp_resp(1'b1, 32'h0000_80FF);
        access(1'b1, 1'b0, 3'b010, 32'h302, 32'h0, 1, 32'h0, ra);
        chk("lw_misaligned_cycle", ra, 1);
        chk("lw_misaligned_req", req_cnt, 0);
        @(posedge clk); #1;
        exp_resp(1'b1, 32'h0000_80FF);
        access(1'b1, 1'b1, 3'b010, 32'h400, 32'h0, 1, 32'h0, ra);
        chk("rd_wr_both_req", req_cnt, 0);
        @(posedge clk); #1;
        exp_resp(1'b1, 32'h0000_80FF);
        access(1'b0, 1'b1, 3'b100, 32'h400, 32'h0, 1, 32'h0, ra);
        @(posedge clk); #1;
        exp_resp(1'b1, 32'h0000_80FF);
        access(1'b1, 1'b0, 3'b011, 32'h400, 32'h0, 1, 32'h0, ra);
        @(posedge clk); #1;
        exp_resp(1'b1, 32'h0000_80FF);
        access(1'b1, 1'b0, 3'b001, 32'h101, 32'h0, 1, 32'h0, ra);

        // Timeout: 16 REQ cycles, then fault; late ack in IDLE ignored
        @(posedge clk); #1;
        exp_bus(32'h500, 1'b0, 32'h0, 4'b0000);
        exp_resp(1'b1, 32'h0000_80FF);
        access(1'b1, 1'b0, 3'b010, 32'h500, 32'h0, 0, 32'h1111_1111, ra);
        chk("timeout_req_cycles", req_cnt, 16);
        chk("timeout_resp_cycle", ra, 17);
        @(posedge clk); #1; bus_ack = 1'b1;
        @(posedge clk); #1; bus_ack = 1'b0;
        chk("late_ack_ignored", {bus_req, stall, done, fault}, 4'b0000);

        // Ack on the final timeout cycle wins
        @(posedge clk); #1;
        exp_bus(32'h504, 1'b0, 32'h0, 4'b0000);
        exp_resp(1'b0, 32'h0BAD_F00D);
        access(1'b1, 1'b0, 3'b010, 32'h504, 32'h0, 16, 32'h0BAD_F00D, ra);
        chk("ack_at_timeout_req", req_cnt, 16);

        // Reset during the 3rd REQ cycle
        @(posedge clk); #1;
        exp_bus(32'h40, 1'b0, 32'h0, 4'b0000);
        mem_read = 1'b1; funct3 = 3'b010; addr = 32'h40;
        repeat (3) @(posedge clk);
        #1; rst = 1'b0;
        #1;
        chk("rst_mid_req_stall", {bus_req, stall, done, fault}, 4'b0000);
        chk("rst_mid_load", load_data, 32'h0);
        mem_read = 1'b0;
        @(posedge clk); #1; rst = 1'b1;
        @(posedge clk); #1;
        chk("rst_release_idle", {bus_req, stall, done, fault}, 4'b0000);
        exp_bus(32'h600, 1'b0, 32'h0, 4'b0000);
        exp_resp(1'b0, 32'hCAFE_F00D);
        access(1'b1, 1'b0, 3'b010, 32'h600, 32'h0, 1, 32'hCAFE_F00D, ra);

        // Back-to-back lw then sw: new request applied in the cycle after RESP
        @(posedge clk); #1;
        exp_bus(32'h10, 1'b0, 32'h0, 4'b0000);
        exp_resp(1'b0, 32'h1234_5678);
        access(1'b1, 1'b0, 3'b010, 32'h10, 32'h0, 1, 32'h1234_5678, ra);
        fork
            begin
                exp_bus(32'h10, 1'b1, 32'hA5A5_5A5A, 4'b1111);
                exp_resp(1'b0, 32'h1234_5678);
                @(posedge clk); #1;
                access(1'b0, 1'b1, 3'b010, 32'h10, 32'hA5A5_5A5A, 2, 32'hFFFF_FFFF, ra);
                chk("b2b_req_cycles", req_cnt, 2);
            end
            begin
                @(posedge clk); #2;
                chk("b2b_idle_no_req", bus_req, 1'b0);
                @(posedge clk); #2;
                chk("b2b_req_rise", bus_req, 1'b1);
                chk("b2b_load_held", load_data, 32'h1234_5678);
            end
        join

        repeat (3) @(posedge clk);
        #1;
        chk("queues_drained", resp_q.size() + bus_q.size(), 0);
        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

    initial begin
        #200000;
        $display("FAIL watchdog: got no completion expected $finish before 200us");
        $fatal(1);
    end

endmodule

// File: doc/lsu_bus_unit.md
Name: lsu_bus_unit

Overview:
Load/store unit directly downstream of the ALU in the RV32I datapath. It takes the ALU result as the effective address, rs2 as store data and funct3 as access size. It runs a multi-cycle req/ack transaction on the data-memory bus and stalls the core until the access completes. It returns sign- or zero-extended load data for register writeback and flags misaligned, illegal and timed-out accesses.

Parameters:
TIMEOUT_CYCLES, 16, maximum cycles in REQ awaiting bus_ack before the access is aborted with a fault (≥2).
CNT_W, 5, width of timeout counter; must hold TIMEOUT_CYCLES.

Ports:
clk  input  1  system clock, rising edge.
rst  input  1  asynchronous, active-low reset.
mem_read  input  1  load requested by control (level, held while stalled).
mem_write  input  1  store requested by control (level, held while stalled).
funct3  input  3  access size/sign: 000 lb, 001 lh, 010 lw, 100 lbu, 101 lhu; stores use 000/001/010.
addr  input  32  effective address (ALU output).
store_data  input  32  rs2 value.
bus_req  output  1  transaction request, held until ack.
bus_we  output  1  1 = write.
bus_addr  output  32  word-aligned address ({addr[31:2],2'b00}).
bus_wdata  output  32  lane-replicated write data.
bus_wstrb  output  4  byte enables (0000 on reads).
bus_ack  input  1  one-cycle completion strobe from memory.
bus_rdata  input  32  read word, valid when bus_ack=1.
load_data  output  32  extended load result.
stall  output  1  freeze PC/regfile write this cycle.
done  output  1  one-cycle pulse: access completed successfully.
fault  output  1  one-cycle pulse: misaligned, illegal or timeout.

Behaviour:
- Reset (rst=0, async): state IDLE; bus_req, bus_we, done, fault, stall = 0; bus_addr, bus_wdata, bus_wstrb, load_data = 0; timeout counter = 0. Reset in any state aborts the access immediately and drops bus_req without waiting for ack.
- States: IDLE, REQ, RESP.
- IDLE, no request: stall=0.
- IDLE, request legal: stall=1 combinationally. On the edge, latch bus_addr, bus_we, bus_wdata and bus_wstrb from the current inputs, set bus_req=1, clear counter, and go to REQ.
- IDLE, request illegal: go to RESP with fault flagged and no bus activity; stall=1 this cycle. Illegal means any of: mem_read and mem_write both 1; funct3 not listed (stores: not 000/001/010); halfword with addr[0]=1; word with addr[1:0]≠00.
- REQ: bus outputs stable and stall=1. Counter increments each cycle without ack.
  - On bus_ack: drop bus_req; if read, register the extended load_data; go to RESP with success.
  - Counter reaching TIMEOUT_CYCLES-1 with no ack: drop bus_req; go to RESP with fault. load_data is unchanged.
  - An ack on the same cycle as the timeout wins.
- RESP: exactly one cycle. stall=0, and done or fault =1 (mutually exclusive). Always returns to IDLE, ignoring mem_read/mem_write this cycle, because they belong to the retiring instruction.
- Store lanes, with o = addr[1:0]:
  - sb: wdata = byte replicated ×4; wstrb = 0001<<o.
  - sh: wdata = halfword replicated ×2; wstrb = 0011 if o=00, 1100 if o=10.
  - sw: wdata = store_data; wstrb = 1111.
- Load extraction uses latched o:
  - lb/lbu: byte rdata[8o+7:8o], sign-/zero-extended.
  - lh/lhu: halfword from rdata[15:0] (o=00) or rdata[31:16] (o=10), sign-/zero-extended.
  - lw: full word.
- load_data holds its value until the next successful load. Stores do not alter it.
- Minimum latency: ack in the first REQ cycle gives 3 cycles from request to done, with stall high for 2 cycles.
- bus_ack outside REQ is ignored.

Test Plan:
1. Load: lb at addr 0x103, ack after 2 cycles with rdata 0x80FF_1234 -> bus_addr 0x100, wstrb 0000; load_data 0xFFFF_FF80, done pulse, stall high 3 cycles. Repeat as lbu -> 0x0000_0080.
2. Stores: sh at 0x202, store_data 0xDEAD_BEEF -> bus_addr 0x200, wdata 0xBEEF_BEEF, wstrb 1100. sb at 0x201 -> wstrb 0010, wdata 0xEFEF_EFEF.
3. Misalignment: lw at 0x302 -> no bus_req ever; fault pulse in cycle 2; load_data unchanged. Also mem_read=mem_write=1 -> fault, no bus activity.
4. Timeout: TIMEOUT_CYCLES=16, no ack -> bus_req high exactly 16 cycles, then a fault pulse; a late ack in IDLE is ignored.
5. Reset mid-operation: rst low in the 3rd REQ cycle -> bus_req and stall drop asynchronously; after release the unit is IDLE and the next lw completes normally.
6. Back-to-back: lw (rdata 0x1234_5678) then sw at 0x10 -> the second bus_req rises in the cycle after RESP; load_data stays 0x1234_5678 through the store.
